// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin arbiter sharing the register file write port
// among NUM_REQ writeback sources, with a pending-write mask and conflict counter.
//
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   hold_i            freeze arbitration, no grants while high
//   req_valid_i       per-source write request
//   req_rd_i          packed dest index, source k at [k*ADDR_W +: ADDR_W]
//   req_data_i        packed write data, same packing
//   req_ready_o       one-hot grant, transfer on valid&ready
//   reg_write_o       register file write enable (registered)
//   rd_o              register file write index (registered)
//   write_data_o      register file write data (registered)
//   pend_mask_o       bit r set while register r has an uncommitted write
//   conflict_cnt_o    saturating count of cycles with >=2 valid requests
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      hold_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*ADDR_W-1:0] req_rd_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic                      reg_write_o,
  output logic [ADDR_W-1:0]         rd_o,
  output logic [DATA_W-1:0]         write_data_o,
  output logic [(1<<ADDR_W)-1:0]    pend_mask_o,
  output logic [15:0]               conflict_cnt_o
);

  localparam int PW = $clog2(NUM_REQ);
  localparam int MW = 1 << ADDR_W;

  logic [PW-1:0]     ptr_q, ptr_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] rd_q, rd_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [15:0]       cnt_q, cnt_d;

  logic [NUM_REQ-1:0] gnt;
  logic [PW-1:0]      gnt_idx;
  logic [PW-1:0]      j;
  logic               found;
  logic [ADDR_W-1:0]  sel_rd;
  logic [DATA_W-1:0]  sel_data;
  logic [3:0]         nv;
  logic [MW-1:0]      mask;

  // Search starting at ptr, wrapping; first valid source wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    j       = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = PW'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && req_valid_i[j]) begin
        found   = 1'b1;
        gnt_idx = j;
      end
    end
    if (hold_i || reset) found = 1'b0;
    if (found) gnt[gnt_idx] = 1'b1;
  end

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt[k]) begin
        sel_rd   = req_rd_i[k*ADDR_W +: ADDR_W];
        sel_data = req_data_i[k*DATA_W +: DATA_W];
      end
    end
  end

  // x0 requests complete the handshake but never reach the write port.
  always_comb begin
    ptr_d  = ptr_q;
    wr_d   = 1'b0;
    rd_d   = rd_q;
    data_d = data_q;
    if (found) begin
      ptr_d = (gnt_idx == PW'(NUM_REQ-1)) ? '0 : gnt_idx + PW'(1);
      if (sel_rd != '0) begin
        wr_d   = 1'b1;
        rd_d   = sel_rd;
        data_d = sel_data;
      end
    end
  end

  always_comb begin
    nv = '0;
    for (int k = 0; k < NUM_REQ; k++) nv = nv + 4'(req_valid_i[k]);
    cnt_d = cnt_q;
    if (nv >= 4'd2 && cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
  end

  always_comb begin
    mask = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (req_valid_i[k]) mask[req_rd_i[k*ADDR_W +: ADDR_W]] = 1'b1;
    end
    if (wr_q) mask[rd_q] = 1'b1;
    mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= '0;
      data_q <= '0;
      cnt_q  <= '0;
    end else begin
      ptr_q  <= ptr_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      data_q <= data_d;
      cnt_q  <= cnt_d;
    end
  end

  assign req_ready_o    = gnt;
  assign reg_write_o    = wr_q;
  assign rd_o           = rd_q;
  assign write_data_o   = data_q;
  assign pend_mask_o    = mask;
  assign conflict_cnt_o = cnt_q;

endmodule
